// File: rtl/imem_boot_loader_if.sv
// Stream-in and instruction-memory write-port bundle for imem_boot_loader.
// slave = loader side, master = stream source / memory side.
interface imem_boot_loader_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a program image (header, payload, optional checksum) into instruction memory
// and holds the datapath in reset until loaded. Macro IMEM_LOADER_CHECKSUM_EN enables the checksum word.
module imem_boot_loader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_rst,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK  = 3'd3,
`endif
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Where the image goes once the payload is exhausted
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = CHK;
`else
    localparam state_t ST_TAIL = DONE;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   len, len_nxt;
    logic [CNT_W-1:0]   words_nxt;
    logic               wr_en_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [WIDTH-1:0]   wr_data_nxt;
    logic               cpu_rst_nxt, busy_nxt, done_nxt, error_nxt;
    logic               xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]   sum, sum_nxt;
`endif

    // in_ready is a pure decode of the current state
    always_comb begin
        bus.in_ready = 1'b0;
        case (state)
            HDR, LOAD: bus.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:       bus.in_ready = 1'b1;
`endif
            default:   bus.in_ready = 1'b0;
        endcase
    end

    assign xfer = bus.in_valid & bus.in_ready;

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        words_nxt   = words_loaded;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = bus.wr_addr;
        wr_data_nxt = bus.wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_nxt     = sum;
`endif
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = HDR;
                    words_nxt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_nxt   = '0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    len_nxt = bus.in_data[ADDR_W:0];
                    if (bus.in_data > WIDTH'(DEPTH))
                        state_nxt = ERR;
                    else if (bus.in_data[ADDR_W:0] == '0)
                        state_nxt = ST_TAIL;
                    else
                        state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = words_loaded[ADDR_W-1:0];
                    wr_data_nxt = bus.in_data;
                    words_nxt   = words_loaded + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_nxt     = sum + bus.in_data;
`endif
                    if (words_loaded + CNT_W'(1) == len)
                        state_nxt = ST_TAIL;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer)
                    state_nxt = (bus.in_data == sum) ? DONE : ERR;
            end
`endif
            default: state_nxt = IDLE;
        endcase

        busy_nxt    = (state_nxt == HDR) || (state_nxt == LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      || (state_nxt == CHK)
`endif
                      ;
        done_nxt    = (state_nxt == DONE);
        error_nxt   = (state_nxt == ERR);
        cpu_rst_nxt = (state_nxt != DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            len          <= '0;
            words_loaded <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            state        <= state_nxt;
            len          <= len_nxt;
            words_loaded <= words_nxt;
            bus.wr_en    <= wr_en_nxt;
            bus.wr_addr  <= wr_addr_nxt;
            bus.wr_data  <= wr_data_nxt;
            cpu_rst      <= cpu_rst_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= sum_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expected writes, a negedge monitor checks them.
// Follows IMEM_LOADER_CHECKSUM_EN to decide whether a checksum word is sent.
module tb_imem_boot_loader;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              cpu_rst, busy, done, error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img[$];
    logic [31:0] ck;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            end
        end
    end

    // Present one word until accepted; payload words push their expected write
    task automatic send_word(input logic [31:0] d, input bit payload, input int addr);
        bit ok = 1'b0;
        int n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                if (payload) begin
                    exp_q.push_back('{addr: ADDR_W'(addr), data: d});
                    ck = ck + d;
                end
            end
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_ready for %h expected acceptance", d);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic settle();
        idle();
        @(negedge clk);
    endtask

    task automatic send_payload(input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            send_word(img[i], 1'b1, i);
            if (gap) idle();
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_checksum(input logic [31:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(c, 1'b0, 0);
`else
        if (c === 32'hxxxx_xxxx) $display("unreachable");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        ck = '0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: three-word program
        img = '{32'h2008_0005, 32'h2009_0007, 32'h0109_5020};
        ck = '0;
        pulse_start();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        send_word(32'd3, 1'b0, 0);
        send_payload(0, 2, 1'b0);
        send_checksum(32'h411A_502C);
        settle();
        check("t1_done", 64'(done), 64'd1);
        check("t1_cpu_rst", 64'(cpu_rst), 64'd0);
        check("t1_error", 64'(error), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_words", 64'(words_loaded), 64'd3);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // Restart from DONE re-asserts cpu_rst immediately
        pulse_start();
        check("t2_cpu_rst_restart", 64'(cpu_rst), 64'd1);
        check("t2_done_cleared", 64'(done), 64'd0);
        check("t2_words_cleared", 64'(words_loaded), 64'd0);
        ck = '0;
        send_word(32'd3, 1'b0, 0);
        send_payload(0, 2, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        // 2: wrong checksum
        send_checksum(32'h3011_502D);
        settle();
        check("t2_error", 64'(error), 64'd1);
        check("t2_cpu_rst", 64'(cpu_rst), 64'd1);
        check("t2_done", 64'(done), 64'd0);
`else
        settle();
        check("t2_done", 64'(done), 64'd1);
`endif
        check("t2_words", 64'(words_loaded), 64'd3);

        // 3: oversize header errors with no writes
        pulse_start();
        check("t3_error_cleared", 64'(error), 64'd0);
        send_word(32'd65, 1'b0, 0);
        settle();
        check("t3_error", 64'(error), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_in_ready", 64'(bus.in_ready), 64'd0);
        check("t3_cpu_rst", 64'(cpu_rst), 64'd1);
        check("t3_words", 64'(words_loaded), 64'd0);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Full-depth image: last write lands on DEPTH-1
        img.delete();
        for (int i = 0; i < 64; i++) img.push_back((32'(i) * 32'h0101_0101) ^ 32'h0000_00A5);
        ck = '0;
        pulse_start();
        send_word(32'd64, 1'b0, 0);
        send_payload(0, 63, 1'b0);
        send_checksum(ck);
        settle();
        check("t3b_done", 64'(done), 64'd1);
        check("t3b_words", 64'(words_loaded), 64'd64);
        check("t3b_last_addr", 64'(bus.wr_addr), 64'd63);
        check("t3b_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: empty image
        pulse_start();
        send_word(32'd0, 1'b0, 0);
        send_checksum(32'd0);
        settle();
        check("t4_done", 64'(done), 64'd1);
        check("t4_error", 64'(error), 64'd0);
        check("t4_words", 64'(words_loaded), 64'd0);

        // 5: in_valid toggling during LOAD
        img = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003, 32'h1234_5678};
        ck = '0;
        pulse_start();
        send_word(32'd4, 1'b0, 0);
        send_payload(0, 3, 1'b1);
        send_checksum(ck);
        settle();
        check("t5_done", 64'(done), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd4);
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: reset mid-load, reload, start ignored while busy
        img = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        ck = '0;
        pulse_start();
        send_word(32'd3, 1'b0, 0);
        send_payload(0, 1, 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_in_ready", 64'(bus.in_ready), 64'd0);
        check("t6_wr_en", 64'(bus.wr_en), 64'd0);
        check("t6_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("t6_wr_data", 64'(bus.wr_data), 64'd0);
        check("t6_cpu_rst", 64'(cpu_rst), 64'd1);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_error", 64'(error), 64'd0);
        check("t6_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ck = '0;
        pulse_start();
        send_word(32'd3, 1'b0, 0);
        send_payload(0, 0, 1'b0);
        pulse_start();
        check("t6_busy_after_start", 64'(busy), 64'd1);
        check("t6_words_after_start", 64'(words_loaded), 64'd1);
        send_payload(1, 2, 1'b0);
        send_checksum(ck);
        settle();
        check("t6_done_reload", 64'(done), 64'd1);
        check("t6_words_reload", 64'(words_loaded), 64'd3);
        check("t6_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
